// File: rtl/approx_pkg.sv
// Shared types and constants for the approximate window accumulator.
package approx_pkg;

   localparam int unsigned DATA_W = 16;

   localparam logic [DATA_W-1:0] SAT_VALUE = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE,
      ACC,
      HOLD
   } state_t;

endpackage

// File: rtl/cla_16_4.sv
// 16-bit approximate carry-lookahead adder: every carry looks back at most four bit positions,
// so carry chains longer than four bits are dropped (cin counts as a generate below bit 0).
module cla_16_4
   import approx_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              cin,
   output logic [DATA_W-1:0] sum,
   output logic              cout
);

   logic [DATA_W-1:0] p;
   logic [DATA_W-1:0] g;
   logic [DATA_W:0]   c;

   // Position j of the operands sits at index j+4; cin sits at index 3, below that is zero.
   logic [19:1] gx;
   logic [19:2] px;

   assign p  = a ^ b;
   assign g  = a & b;
   assign gx = {g, cin, 2'b00};
   assign px = {p, 2'b00};

   assign c[0] = cin;

   for (genvar i = 1; i <= DATA_W; i++) begin : g_carry
      assign c[i] = gx[i+3]
                  | (px[i+3] & gx[i+2])
                  | (px[i+3] & px[i+2] & gx[i+1])
                  | (px[i+3] & px[i+2] & px[i+1] & gx[i]);
   end

   assign sum  = p ^ c[DATA_W-1:0];
   assign cout = c[DATA_W];

endmodule

// File: rtl/approx_acc_16.sv
// Window accumulator for a CNN MAC lane: sums LEN partial products through cla_16_4 and
// hands each window result downstream with a sticky overflow flag.
module approx_acc_16
   import approx_pkg::*;
#(
   parameter int unsigned LEN = 9,
   parameter bit          SAT = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_ovf,
   output logic              out_valid,
   input  logic              out_ready
);

   localparam int unsigned      CNT_W = $clog2(LEN + 1);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(LEN - 1);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ovf_q, ovf_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_ovf_q, out_ovf_d;

   logic [DATA_W-1:0] add_a;
   logic [DATA_W-1:0] sum;
   logic              cout;
   logic              in_xfer;
   logic              ovf_win;
   logic              last_term;

   assign in_ready  = (state_q != HOLD);
   assign out_valid = (state_q == HOLD);
   assign in_xfer   = in_valid && in_ready;

   // First term of a window starts from zero so a stale acc never leaks into the next window.
   assign add_a     = (state_q == IDLE) ? '0 : acc_q;
   assign ovf_win   = (state_q == IDLE) ? cout : (ovf_q | cout);
   assign last_term = (state_q == IDLE) ? (LEN == 1) : (cnt_q == LAST);

   cla_16_4 u_add (
      .a    (add_a),
      .b    (in_data),
      .cin  (1'b0),
      .sum  (sum),
      .cout (cout)
   );

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      ovf_d      = ovf_q;
      out_data_d = out_data_q;
      out_ovf_d  = out_ovf_q;
      unique case (state_q)
         IDLE, ACC: begin
            if (in_xfer) begin
               acc_d = sum;
               ovf_d = ovf_win;
               cnt_d = (state_q == IDLE) ? CNT_W'(1) : cnt_q + CNT_W'(1);
               if (last_term) begin
                  state_d    = HOLD;
                  out_data_d = (SAT && ovf_win) ? SAT_VALUE : sum;
                  out_ovf_d  = ovf_win;
               end else begin
                  state_d = ACC;
               end
            end
         end
         HOLD: begin
            if (out_ready) begin
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         acc_q      <= '0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         out_data_q <= '0;
         out_ovf_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
         out_data_q <= out_data_d;
         out_ovf_q  <= out_ovf_d;
      end
   end

   assign out_data = out_data_q;
   assign out_ovf  = out_ovf_q;

endmodule

// File: tb/tb_approx_acc_16.sv
// Directed and random checks of approx_acc_16 in four configurations against a scoreboard
// fed by a bit-level reference model of the approximate adder.
module tb_approx_acc_16;

   typedef struct packed {
      logic [15:0] d;
      logic        o;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        vld  [4];
   logic        rdy  [4];
   logic        ov   [4];
   logic        oo   [4];
   logic        ordy [4];
   logic [15:0] din  [4];
   logic [15:0] od   [4];

   exp_t sb [4][$];
   int   pops [4];
   int   exp_pops [4] = '{102, 2, 2, 2};
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   approx_acc_16 #(.LEN(9), .SAT(1'b1)) dut9 (
      .clk(clk), .rst(rst), .in_data(din[0]), .in_valid(vld[0]), .in_ready(rdy[0]),
      .out_data(od[0]), .out_ovf(oo[0]), .out_valid(ov[0]), .out_ready(ordy[0])
   );
   approx_acc_16 #(.LEN(2), .SAT(1'b1)) dut2s (
      .clk(clk), .rst(rst), .in_data(din[1]), .in_valid(vld[1]), .in_ready(rdy[1]),
      .out_data(od[1]), .out_ovf(oo[1]), .out_valid(ov[1]), .out_ready(ordy[1])
   );
   approx_acc_16 #(.LEN(2), .SAT(1'b0)) dut2w (
      .clk(clk), .rst(rst), .in_data(din[2]), .in_valid(vld[2]), .in_ready(rdy[2]),
      .out_data(od[2]), .out_ovf(oo[2]), .out_valid(ov[2]), .out_ready(ordy[2])
   );
   approx_acc_16 #(.LEN(3), .SAT(1'b1)) dut3 (
      .clk(clk), .rst(rst), .in_data(din[3]), .in_valid(vld[3]), .in_ready(rdy[3]),
      .out_data(od[3]), .out_ovf(oo[3]), .out_valid(ov[3]), .out_ready(ordy[3])
   );

   // Reference adder: walk down from each bit, at most four positions, looking for a generate
   // reached through an unbroken run of propagates.
   function automatic logic [16:0] cla_model(input logic [15:0] a, input logic [15:0] b);
      logic [15:0] gv;
      logic [15:0] pv;
      logic [16:0] cv;
      gv = a & b;
      pv = a ^ b;
      cv = '0;
      for (int i = 1; i <= 16; i++) begin
         for (int j = i - 1; j >= 0 && j >= i - 4; j--) begin
            if (((gv >> j) & 16'd1) != 16'd0) begin
               cv = cv | (17'd1 << i);
               break;
            end
            if (((pv >> j) & 16'd1) == 16'd0) break;
         end
      end
      return {cv[16], pv ^ cv[15:0]};
   endfunction

   task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int k, input logic [15:0] d, input logic o);
      exp_t e;
      e.d = d;
      e.o = o;
      sb[k].push_back(e);
   endtask

   // Called just after a falling edge; returns just after the falling edge following the transfer.
   task automatic send(input int k, input logic [15:0] d);
      int n = 0;
      vld[k] = 1'b1;
      din[k] = d;
      while (rdy[k] !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      total++;
      assert (rdy[k] === 1'b1) else begin
         bad++;
         $error("FAIL send_timeout%0d: observed in_ready %b expected 1", k, rdy[k]);
      end
      if (rdy[k] === 1'b1) @(negedge clk);
      vld[k] = 1'b0;
      din[k] = 16'($urandom);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Output monitor: pops the scoreboard on every output transfer.
   always begin
      @(negedge clk);
      #1;
      if (!rst) begin
         for (int k = 0; k < 4; k++) begin
            if (ov[k] === 1'b1 && ordy[k] === 1'b1) begin
               total++;
               assert (sb[k].size() != 0) else begin
                  bad++;
                  $error("FAIL spurious_out%0d: observed extra result %0h expected none", k, od[k]);
               end
               if (sb[k].size() != 0) begin
                  exp_t e;
                  e = sb[k].pop_front();
                  chk($sformatf("out_data%0d", k), {1'b0, od[k]}, {1'b0, e.d});
                  chk($sformatf("out_ovf%0d", k), {16'd0, oo[k]}, {16'd0, e.o});
                  pops[k]++;
               end
            end
         end
      end
   end

   initial begin
      logic [15:0] wd [9];
      logic [16:0] r;
      logic [15:0] acc;
      logic        ovf;

      for (int k = 0; k < 4; k++) begin
         vld[k]  = 1'b0;
         din[k]  = '0;
         ordy[k] = 1'b1;
         pops[k] = 0;
      end
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("rst_in_ready%0d", k), {16'd0, rdy[k]}, 17'd1);
         chk($sformatf("rst_out_valid%0d", k), {16'd0, ov[k]}, 17'd0);
         chk($sformatf("rst_out_data%0d", k), {1'b0, od[k]}, 17'd0);
         chk($sformatf("rst_out_ovf%0d", k), {16'd0, oo[k]}, 17'd0);
      end

      // LEN=9: 1..9 back to back sums to 45; in_ready drops for exactly one cycle.
      push(0, 16'h002D, 1'b0);
      for (int i = 1; i <= 9; i++) send(0, 16'(i));
      chk("hold_in_ready", {16'd0, rdy[0]}, 17'd0);
      chk("hold_out_valid", {16'd0, ov[0]}, 17'd1);
      @(negedge clk);
      chk("after_in_ready", {16'd0, rdy[0]}, 17'd1);
      chk("after_out_valid", {16'd0, ov[0]}, 17'd0);

      // LEN=2: approximate carry drop, then overflow with and without saturation.
      push(1, 16'h00E0, 1'b0);
      send(1, 16'h00FF);
      send(1, 16'h0001);
      push(1, 16'hFFFF, 1'b1);
      send(1, 16'h8000);
      send(1, 16'h8000);
      push(2, 16'h0000, 1'b1);
      send(2, 16'h8000);
      send(2, 16'h8000);
      push(2, 16'h00E0, 1'b0);
      send(2, 16'h00FF);
      send(2, 16'h0001);

      // LEN=3 backpressure: result held stable and the next input waits.
      ordy[3] = 1'b0;
      push(3, 16'd15, 1'b0);
      send(3, 16'd4);
      send(3, 16'd5);
      send(3, 16'd6);
      vld[3] = 1'b1;
      din[3] = 16'd7;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("bp_in_ready_c%0d", i), {16'd0, rdy[3]}, 17'd0);
         chk($sformatf("bp_out_valid_c%0d", i), {16'd0, ov[3]}, 17'd1);
         chk($sformatf("bp_out_data_c%0d", i), {1'b0, od[3]}, 17'd15);
         chk($sformatf("bp_out_ovf_c%0d", i), {16'd0, oo[3]}, 17'd0);
         @(negedge clk);
      end
      ordy[3] = 1'b1;
      push(3, 16'd9, 1'b0);
      send(3, 16'd7);
      send(3, 16'd1);
      send(3, 16'd1);
      idle(3);

      // LEN=9 random windows with ~50% input bubbles.
      for (int w = 0; w < 100; w++) begin
         acc = '0;
         ovf = 1'b0;
         for (int i = 0; i < 9; i++) begin
            wd[i] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h1FFF));
            r     = cla_model((i == 0) ? 16'h0000 : acc, wd[i]);
            acc   = r[15:0];
            ovf   = ovf | r[16];
         end
         push(0, ovf ? 16'hFFFF : acc, ovf);
         for (int i = 0; i < 9; i++) begin
            if ($urandom_range(0, 1) == 1) idle(1);
            send(0, wd[i]);
         end
      end
      idle(4);

      // Reset after 4 of 9 terms: the partial window must vanish without an output.
      for (int i = 0; i < 4; i++) send(0, 16'h1234);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_in_ready", {16'd0, rdy[0]}, 17'd1);
      chk("midrst_out_valid", {16'd0, ov[0]}, 17'd0);
      chk("midrst_out_data", {1'b0, od[0]}, 17'd0);
      push(0, 16'd18, 1'b0);
      for (int i = 0; i < 9; i++) send(0, 16'd2);
      idle(4);

      for (int k = 0; k < 4; k++) begin
         chk($sformatf("leftover%0d", k), 17'(sb[k].size()), 17'd0);
         chk($sformatf("windows%0d", k), 17'(pops[k]), 17'(exp_pops[k]));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
